// File: rtl/regfile_pkg.sv
// regfile_pkg: shared types and default sizing for the parameterised register file.
//   state_t      : clear-sequencer FSM states (ST_INIT = clear sweep, ST_READY = normal use)
//   DEF_DATA_W   : default register width
//   DEF_ADDR_W   : default address width (DEPTH = 2**ADDR_W)
//   DEF_NRD      : default number of read ports
package regfile_pkg;

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_t;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_NRD    = 2;

endpackage

// File: rtl/regfile_clr_seq.sv
// regfile_clr_seq: clear-sweep sequencer for regfile_param.
//   clk       in   rising-edge clock
//   rst_n     in   synchronous active-low reset; restarts the sweep at index 0
//   clr       in   soft-clear pulse; (re)starts the sweep at index 0
//   busy      out  1 while the sweep is running (state ST_INIT)
//   sweep_we  out  strobe: write zero to sweep_idx this cycle
//   sweep_idx out  register index being cleared this cycle
module regfile_clr_seq
  import regfile_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  output logic              busy,
  output logic              sweep_we,
  output logic [ADDR_W-1:0] sweep_idx
);

  localparam logic [ADDR_W-1:0] LAST_IDX = '1;

  state_t            state, state_nx;
  logic [ADDR_W-1:0] clr_idx, idx_nx;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_INIT;
      clr_idx <= '0;
    end else begin
      state   <= state_nx;
      clr_idx <= idx_nx;
    end
  end

  always_comb begin
    state_nx = state;
    idx_nx   = clr_idx;
    case (state)
      ST_INIT: begin
        if (clr) begin
          idx_nx = '0;
        end else if (clr_idx == LAST_IDX) begin
          // Last register cleared on this edge; index parks at 0 so it never wraps mid-sweep.
          state_nx = ST_READY;
          idx_nx   = '0;
        end else begin
          idx_nx = clr_idx + 1'b1;
        end
      end
      ST_READY: begin
        if (clr) begin
          state_nx = ST_INIT;
          idx_nx   = '0;
        end
      end
      default: begin
        state_nx = ST_INIT;
        idx_nx   = '0;
      end
    endcase
  end

  assign busy      = (state == ST_INIT);
  assign sweep_we  = busy;
  assign sweep_idx = clr_idx;

endmodule

// File: rtl/regfile_param.sv
// regfile_param: parameterised multi-read-port register file with clear sweep.
//   clk      in   rising-edge clock
//   rst_n    in   synchronous active-low reset (array itself is cleared by the sweep)
//   clr      in   soft-clear pulse
//   wr_en    in   write request
//   wr_addr  in   write address
//   wr_data  in   write data
//   wr_rdy   out  write accepted this cycle when wr_en is high
//   rd_addr  in   NRD packed read addresses, port k at [k*ADDR_W +: ADDR_W]
//   rd_data  out  NRD packed read data, port k at [k*DATA_W +: DATA_W]
//   busy     out  clear sweep in progress
// Build option: define REGF_BYPASS_EN to forward a committing write to matching read ports.
module regfile_param
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NRD      = DEF_NRD,
  parameter int ZERO_REG = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [DATA_W-1:0]     wr_data,
  output logic                  wr_rdy,
  input  logic [NRD*ADDR_W-1:0] rd_addr,
  output logic [NRD*DATA_W-1:0] rd_data,
  output logic                  busy
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic              sweep_we;
  logic [ADDR_W-1:0] sweep_idx;
  logic              wr_commit;
  logic              zero_hit;

  regfile_clr_seq #(
    .ADDR_W (ADDR_W)
  ) u_clr_seq (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .busy      (busy),
    .sweep_we  (sweep_we),
    .sweep_idx (sweep_idx)
  );

  assign wr_rdy    = !busy && !clr;
  assign zero_hit  = (ZERO_REG != 0) && (wr_addr == '0);
  // rst_n gating abandons a write that coincides with reset.
  assign wr_commit = rst_n && wr_en && wr_rdy && !zero_hit;

  always_ff @(posedge clk) begin
    if (sweep_we) begin
      mem[sweep_idx] <= '0;
    end else if (wr_commit) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    logic [ADDR_W-1:0] a;
    rd_data = '0;
    a       = '0;
    for (int unsigned k = 0; k < NRD; k++) begin
      a = rd_addr[k*ADDR_W +: ADDR_W];
      if (busy) begin
        rd_data[k*DATA_W +: DATA_W] = '0;
      end else if ((ZERO_REG != 0) && (a == '0)) begin
        rd_data[k*DATA_W +: DATA_W] = '0;
`ifdef REGF_BYPASS_EN
      end else if (wr_commit && (a == wr_addr)) begin
        rd_data[k*DATA_W +: DATA_W] = wr_data;
`endif
      end else begin
        rd_data[k*DATA_W +: DATA_W] = mem[a];
      end
    end
  end

endmodule

// File: tb/tb_regfile_param.sv
// tb_regfile_param: randomized + directed bench for regfile_param (default parameters).
// Works with or without REGF_BYPASS_EN defined.
module tb_regfile_param;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int NR    = 2;
  localparam int DEPTH = 32;
`ifdef REGF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic             clr;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [DW-1:0]    wr_data;
  logic             wr_rdy;
  logic [NR*AW-1:0] rd_addr;
  logic [NR*DW-1:0] rd_data;
  logic             busy;

  int checks = 0;
  int errors = 0;

  regfile_param #(
    .DATA_W   (DW),
    .ADDR_W   (AW),
    .NRD      (NR),
    .ZERO_REG (1)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (clr),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .wr_rdy  (wr_rdy),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  // Behavioural model: register contents + number of sweep cycles left.
  logic [DW-1:0] mdl [DEPTH];
  int            sweep_left = 0;
  bit            mdl_valid  = 1'b0;

  task automatic mdl_start_sweep();
    sweep_left = DEPTH;
    for (int i = 0; i < DEPTH; i++) mdl[i] = '0;
  endtask

  always @(posedge clk) begin
    if (!rst_n) begin
      mdl_valid = 1'b1;
      mdl_start_sweep();
    end else if (mdl_valid) begin
      if (sweep_left > 0) begin
        if (clr) mdl_start_sweep();
        else     sweep_left--;
      end else if (clr) begin
        mdl_start_sweep();
      end else if (wr_en && wr_addr != 0) begin
        mdl[wr_addr] = wr_data;
      end
    end
  end

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] exp_read(input logic [AW-1:0] a);
    bit commit;
    commit = rst_n && wr_en && (sweep_left == 0) && !clr && (wr_addr != 0);
    if (sweep_left > 0) return '0;
    if (a == 0) return '0;
    if (BYP && commit && a == wr_addr) return wr_data;
    return mdl[a];
  endfunction

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    if (mdl_valid) begin
      chk("busy", {31'b0, busy}, {31'b0, (sweep_left > 0)});
      chk("wr_rdy", {31'b0, wr_rdy}, {31'b0, (sweep_left == 0) && !clr});
      for (int k = 0; k < NR; k++)
        chk($sformatf("rd_data[%0d]", k), rd_data[k*DW +: DW], exp_read(rd_addr[k*AW +: AW]));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    clr = 1'b0; wr_en = 1'b0;
  endtask

  // Counts negedges with busy high; bounded so a stuck sweep cannot hang the run.
  task automatic count_busy(input string name, input int exp);
    int n = 0;
    bit done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (busy) n++;
      else      done = 1'b1;
    end
    chk(name, n, exp);
  endtask

  initial begin
    logic [DW-1:0] v;
    rst_n = 1'b0; clr = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_addr = '0;
    repeat (3) step();
    chk("reset_busy", {31'b0, busy}, 32'd1);
    chk("reset_wr_rdy", {31'b0, wr_rdy}, 32'd0);
    chk("reset_rd_data", rd_data[DW-1:0], 32'd0);
    rst_n = 1'b1;
    count_busy("init_busy_cycles", 32);
    for (int r = 0; r < DEPTH; r += 2) begin
      rd_addr = {AW'(r + 1), AW'(r)};
      #1;
      chk("post_sweep_zero_a", rd_data[DW-1:0], 32'd0);
      chk("post_sweep_zero_b", rd_data[2*DW-1:DW], 32'd0);
    end

    // r5 write, read on both ports next cycle
    step();
    wr_en = 1'b1; wr_addr = 5; wr_data = 32'hDEADBEEF;
    step();
    idle(); rd_addr = {AW'(5), AW'(5)};
    @(negedge clk);
    chk("r5_port0", rd_data[DW-1:0], 32'hDEADBEEF);
    chk("r5_port1", rd_data[2*DW-1:DW], 32'hDEADBEEF);

    // r0 is hardwired
    step();
    wr_en = 1'b1; wr_addr = 0; wr_data = 32'h12345678; rd_addr = {AW'(0), AW'(0)};
    step();
    idle();
    @(negedge clk);
    chk("r0_zero", rd_data[DW-1:0], 32'd0);

    // Same-cycle write/read of r7
    step();
    wr_en = 1'b1; wr_addr = 7; wr_data = 32'hA5A5A5A5; rd_addr = {AW'(5), AW'(7)};
    @(negedge clk);
    v = BYP ? 32'hA5A5A5A5 : 32'd0;
    chk("r7_same_cycle", rd_data[DW-1:0], v);
    step();
    idle();
    @(negedge clk);
    chk("r7_next_cycle", rd_data[DW-1:0], 32'hA5A5A5A5);

    // clr with concurrent write to r3
    step();
    clr = 1'b1; wr_en = 1'b1; wr_addr = 3; wr_data = 32'h1; rd_addr = {AW'(7), AW'(3)};
    step();
    idle();
    count_busy("clr_busy_cycles", 32);
    chk("r3_after_clr", rd_data[DW-1:0], 32'd0);
    chk("r7_after_clr", rd_data[2*DW-1:DW], 32'd0);

    // Reset in the middle of a sweep (index 10)
    step();
    clr = 1'b1;
    step();
    clr = 1'b0;
    repeat (10) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    count_busy("midsweep_reset_busy", 32);

    // Randomized phase
    for (int c = 0; c < 3000; c++) begin
      step();
      rst_n   = ($urandom_range(0, 299) != 0);
      clr     = ($urandom_range(0, 79) == 0);
      wr_en   = ($urandom_range(0, 1) == 1);
      wr_addr = AW'($urandom_range(0, 7) == 0 ? 0 : $urandom_range(0, DEPTH - 1));
      wr_data = $urandom;
      for (int k = 0; k < NR; k++) begin
        if ($urandom_range(0, 3) == 0) rd_addr[k*AW +: AW] = wr_addr;
        else                           rd_addr[k*AW +: AW] = AW'($urandom_range(0, DEPTH - 1));
      end
    end
    step();
    idle(); rst_n = 1'b1;
    repeat (2) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_param.md
REGFILE_PARAM -- requirements
Module: regfile_param

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register width in bits.
REQ-002 SHALL have parameter ADDR_W, default 5, address width; DEPTH = 2**ADDR_W registers.
REQ-003 SHALL have parameter NRD, default 2, number of read ports.
REQ-004 SHALL have parameter ZERO_REG, default 1; 1 = register 0 hardwired to zero.
REQ-005 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-007 SHALL have port clr  input  1  soft-clear request, single-cycle pulse.
REQ-008 SHALL have port wr_en  input  1  write request.
REQ-009 SHALL have port wr_addr  input  ADDR_W  write address.
REQ-010 SHALL have port wr_data  input  DATA_W  write data.
REQ-011 SHALL have port wr_rdy  output  1  write accepted this cycle when wr_en is also high.
REQ-012 SHALL have port rd_addr  input  NRD*ADDR_W  read addresses; port k occupies bits [k*ADDR_W +: ADDR_W].
REQ-013 SHALL have port rd_data  output  NRD*DATA_W  read data; port k occupies bits [k*DATA_W +: DATA_W].
REQ-014 SHALL have port busy  output  1  clear sweep in progress.

Function
REQ-015 SHALL implement a two-state FSM: INIT (clear sweep) and READY.
REQ-016 In INIT, SHALL write 0 to register clr_idx each cycle and increment clr_idx.
REQ-017 INIT -> READY SHALL occur on the edge that clears register DEPTH-1; INIT therefore lasts exactly DEPTH cycles.
REQ-018 busy SHALL be 1 in INIT and 0 in READY.
REQ-019 wr_rdy SHALL be (state==READY) && !clr, combinationally.
REQ-020 A write SHALL be committed at the rising edge when wr_en && wr_rdy, except wr_addr==0 with ZERO_REG=1, which is silently dropped.
REQ-021 Reads SHALL be combinational (zero latency) from the array on all NRD ports independently; identical addresses on several ports SHALL return identical data.
REQ-022 rd_data on every port SHALL be 0 while busy=1.
REQ-023 With ZERO_REG=1, a read of address 0 SHALL return 0 under all conditions.
REQ-024 clr in READY SHALL enter INIT on the next edge with clr_idx=0; any concurrent write SHALL be dropped.
REQ-025 clr in INIT SHALL restart the sweep at clr_idx=0; DEPTH more cycles SHALL follow.
REQ-026 wr_en while busy=1 SHALL have no effect and SHALL NOT be queued.
REQ-027 clr_idx SHALL be ADDR_W bits wide and SHALL NOT wrap past DEPTH-1 within one sweep.

Reset
REQ-028 While rst_n=0 at a rising edge, SHALL set state=INIT, clr_idx=0, busy=1, wr_rdy=0 and rd_data=0.
REQ-029 The array SHALL NOT be reset directly; contents become zero only through the INIT sweep.
REQ-030 Reset asserted mid-sweep or mid-write SHALL abandon the operation and restart the sweep at index 0.

Configuration
REQ-031 Macro REGF_BYPASS_EN: when defined, a read port whose address equals a write address being committed this cycle SHALL return wr_data combinationally; without it, that port SHALL return the pre-write value.
REQ-032 Bypass SHALL NOT apply to dropped writes (address 0 with ZERO_REG=1, busy, or clr).

Structure
REQ-033 Package regfile_pkg SHALL hold the FSM state typedef (ST_INIT, ST_READY) and the default DATA_W/ADDR_W/NRD constants.
REQ-034 Sub-module regfile_clr_seq SHALL contain the FSM and the clr_idx counter, and SHALL drive busy and the sweep write strobe/index; regfile_param SHALL contain the array, write muxing and read ports.

Verification
REQ-035 Reset released at cycle 0 -> busy=1 for 32 cycles, then busy=0; all 32 registers read 0.
REQ-036 After sweep: write 0xDEADBEEF to r5, then read r5 on port 0 and port 1 next cycle -> both 0xDEADBEEF.
REQ-037 Write 0x12345678 to r0 -> r0 reads 0 (ZERO_REG=1).
REQ-038 Same-cycle write 0xA5A5A5A5 to r7 while reading r7 -> 0xA5A5A5A5 with REGF_BYPASS_EN defined, old value without it; 0xA5A5A5A5 on the next cycle in both builds.
REQ-039 clr pulse together with a write of 0x1 to r3 -> write dropped, busy=1 for 32 cycles, r3 reads 0 afterwards.
REQ-040 rst_n low at sweep index 10 -> sweep restarts at 0; busy=0 exactly 32 cycles after rst_n returns high.
